commit_queue: RTL

In-order buffer between instruction completion and the commit stage. Holds up to DEPTH completed scoreboard entries in program order and presents the oldest one or two entries to the commit stage's commit ports. Pops 0, 1 or 2 entries per cycle according to the commit acknowledges. Drains entirely on a pipeline flush.

---
 rtl/commit_queue.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/commit_queue.sv
// -----------------------------------------------------------------------------
// commit_queue
//
// In-order buffer that sits between instruction completion and the commit
// stage. Completed scoreboard entries are pushed in program order. The oldest
// one or two entries are presented on the commit ports. Each cycle the commit
// stage may retire 0, 1 or 2 of them. A flush discards the whole contents.
//
// Parameters
//   DEPTH            number of entries (power of two, >= 4)
//   NR_COMMIT_PORTS  commit ports presented (1 or 2)
//   ENTRY_WIDTH      payload width; the integration sets this to the width of
//                    the scoreboard entry type
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   rst_i           synchronous active-high reset
//   flush_i         discard all entries (pushes/acks in this cycle dropped)
//   push_valid_i    completed entry offered
//   push_ready_o    space available (purely from state, never from acks)
//   push_data_i     entry payload
//   commit_valid_o  bit i set when port i holds the i-th oldest entry
//   commit_data_o   payloads, port 0 (oldest) in the least significant slice
//   commit_ack_i    commit stage retires port i
//   count_o         current occupancy
//   empty_o         count_o == 0
//   full_o          count_o == DEPTH
//   retired_cnt_o   total entries retired (0 unless COMMIT_QUEUE_PERF_EN)
//
// Build option
//   COMMIT_QUEUE_PERF_EN  when defined, a 64-bit retired-entry counter drives
//                         retired_cnt_o; it clears on reset but not on flush.
//                         When undefined, retired_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module commit_queue #(
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned ENTRY_WIDTH     = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic                                   push_valid_i,
    output logic                                   push_ready_o,
    input  logic [ENTRY_WIDTH-1:0]                 push_data_i,
    output logic [NR_COMMIT_PORTS-1:0]             commit_valid_o,
    output logic [NR_COMMIT_PORTS*ENTRY_WIDTH-1:0] commit_data_o,
    input  logic [NR_COMMIT_PORTS-1:0]             commit_ack_i,
    output logic [$clog2(DEPTH):0]                 count_o,
    output logic                                   empty_o,
    output logic                                   full_o,
    output logic [63:0]                            retired_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Storage is never reset; only the pointers and count define validity.
    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;

    logic                       full;
    logic                       push_en;
    logic [NR_COMMIT_PORTS-1:0] pop;
    logic [1:0]                 pop_cnt;

    // -------------------------------------------------------------------------
    // Status. Ready is derived from registered occupancy only, so a full
    // queue refuses a push even when an entry retires in the same cycle.
    // -------------------------------------------------------------------------
    assign full         = (count_reg == CNT_W'(DEPTH));
    assign full_o       = full;
    assign empty_o      = (count_reg == '0);
    assign push_ready_o = !full;
    assign count_o      = count_reg;

    // A push offered in the flush cycle is dropped.
    assign push_en = push_valid_i && push_ready_o && !flush_i;

    // -------------------------------------------------------------------------
    // Commit ports: port gi shows mem[rd_ptr + gi]; the PTR_W-bit add wraps
    // naturally, so port 1 reads mem[0] when rd_ptr == DEPTH-1.
    // Pops must be contiguous from port 0: an ack is honoured only if every
    // older port is also being retired and the port itself is valid.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_port
            logic [PTR_W-1:0] rd_idx;

            assign rd_idx             = rd_ptr_reg + PTR_W'(gi);
            assign commit_valid_o[gi] = (count_reg > CNT_W'(gi));
            assign commit_data_o[gi*ENTRY_WIDTH +: ENTRY_WIDTH] = mem[rd_idx];

            if (gi == 0) begin : g_head
                assign pop[gi] = commit_ack_i[gi] && commit_valid_o[gi];
            end else begin : g_tail
                assign pop[gi] = pop[gi-1] && commit_ack_i[gi] && commit_valid_o[gi];
            end
        end
    endgenerate

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            pop_cnt = pop_cnt + 2'(pop[i]);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Flush overrides everything except reset.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(pop_cnt);
            wr_ptr_next = wr_ptr_reg + PTR_W'(push_en);
            count_next  = count_reg + CNT_W'(push_en) - CNT_W'(pop_cnt);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Payload write; a push during reset lands in an invalid slot, which is
    // harmless because the pointers are cleared on the same edge.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= push_data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Retired-entry counter. Pops acknowledged in a flush cycle still count.
    // -------------------------------------------------------------------------
`ifdef COMMIT_QUEUE_PERF_EN
    logic [63:0] retired_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired_reg <= '0;
        end else begin
            retired_reg <= retired_reg + 64'(pop_cnt);
        end
    end

    assign retired_cnt_o = retired_reg;
`else
    assign retired_cnt_o = '0;
`endif

    // -------------------------------------------------------------------------
    // Protocol checks on the commit stage. Violations are tolerated by the
    // datapath (the offending ack is simply ignored), so these only warn.
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    generate
        for (genvar gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_chk
            always @(posedge clk_i) begin
                if (!rst_i) begin
                    ack_invalid: assert (!(commit_ack_i[gi] && !commit_valid_o[gi]))
                        else $warning("ack_invalid: ack on empty commit port %0d", gi);
                end
            end
            if (gi > 0) begin : g_order
                always @(posedge clk_i) begin
                    if (!rst_i) begin
                        ack_order: assert (!(commit_ack_i[gi] && !commit_ack_i[gi-1]))
                            else $warning("ack_order: ack on port %0d without older port", gi);
                    end
                end
            end
        end
    endgenerate
`endif

endmodule
